// File: rtl/qddc_pkg.sv
// qddc_pkg: shared types and constants for the quadrature DDC and its tune controller.
package qddc_pkg;

    localparam int QDDC_FSZ = 31;

    typedef enum logic [1:0] {
        FLUSH,
        SETTLE,
        RUN
    } qddc_tune_state_t;

endpackage

// File: rtl/qddc_tune_ctrl.sv
// qddc_tune_ctrl: retune sequencer; flushes the DDC on NCO changes, then discards settling samples.
module qddc_tune_ctrl
    import qddc_pkg::*;
#(
    parameter int FSZ            = QDDC_FSZ,
    parameter int FLUSH_CYCLES   = 8,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [FSZ-1:0] cfg_freq,
    input  logic           cfg_dir,
    input  logic           cfg_ns_en,
    input  logic           cfg_iq_swap,
    input  logic           ddc_strobe,
    output logic           ddc_reset,
    output logic [FSZ-1:0] lo_freq,
    output logic           lo_dir,
    output logic           lo_ns_en,
    output logic           iq_swap,
    output logic           out_valid,
    output logic           retune_done
);

    localparam int CMAX = (FLUSH_CYCLES > SETTLE_SAMPLES) ? FLUSH_CYCLES : SETTLE_SAMPLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] FLUSH_LOAD  = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_SAMPLES);

    qddc_tune_state_t state;
    logic [CW-1:0]    cnt;
    logic             full;

    // Only NCO-affecting fields disturb the CIC state; iq_swap alone does not.
    assign full = cfg_freq != lo_freq || cfg_dir != lo_dir || cfg_ns_en != lo_ns_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FLUSH;
            cnt         <= FLUSH_LOAD;
            lo_freq     <= '0;
            lo_dir      <= 1'b0;
            lo_ns_en    <= 1'b0;
            iq_swap     <= 1'b0;
            ddc_reset   <= 1'b1;
            cfg_ready   <= 1'b0;
            out_valid   <= 1'b0;
            retune_done <= 1'b0;
        end else begin
            retune_done <= 1'b0;
            case (state)
                FLUSH: begin
                    if (cnt == '0) begin
                        state     <= SETTLE;
                        cnt       <= SETTLE_LOAD;
                        ddc_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0 || (ddc_strobe && cnt == CW'(1))) begin
                        state       <= RUN;
                        cfg_ready   <= 1'b1;
                        out_valid   <= 1'b1;
                        retune_done <= 1'b1;
                    end else if (ddc_strobe) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (cfg_valid && cfg_ready) begin
                        iq_swap <= cfg_iq_swap;
                        if (full) begin
                            lo_freq   <= cfg_freq;
                            lo_dir    <= cfg_dir;
                            lo_ns_en  <= cfg_ns_en;
                            state     <= FLUSH;
                            cnt       <= FLUSH_LOAD;
                            ddc_reset <= 1'b1;
                            cfg_ready <= 1'b0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= FLUSH;
                    cnt       <= FLUSH_LOAD;
                    ddc_reset <= 1'b1;
                    cfg_ready <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
